// File: rtl/sorter_pkt_ctrl.sv
// sorter_pkt_ctrl: packet-level controller wrapped around a private sorter.
//   Buffers one sop/eop-framed packet, checks its length, loads it into the
//   sorter, and forwards the ascending result downstream. A sorter that does
//   not finish within TIMEOUT cycles of its last write is reported and cleared.
// Ports:
//   clk_i, rst_n_i                         clock, async active-low reset
//   snk_data_i/sop/eop/val, snk_ready_o    input packet stream (beat = val & ready)
//   src_data_o/sop/eop/val                 sorted output stream, no backpressure
//   err_o, err_code_o                      1-cycle error pulse; 1=short 2=oversize 3=timeout
//   busy_o                                 controller not idle

// sorter_core: insertion sorter. Each write is placed into its sorted position
// in one cycle; after cntr_i words the contents stream out one per cycle.
// Ports: clk_i, srst_i (sync reset), wren_i/data_i (write), cntr_i (packet
// length), data_o/sop_o/eop_o/val_o (registered ascending output).
module sorter_core #(
   parameter int DWIDTH = 8,
   parameter int AWIDTH = 4
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic              wren_i,
   input  logic [DWIDTH-1:0] data_i,
   input  logic [AWIDTH-1:0] cntr_i,
   output logic [DWIDTH-1:0] data_o,
   output logic              sop_o,
   output logic              eop_o,
   output logic              val_o
);
   localparam int DEPTH = 2**AWIDTH;

   typedef enum logic {S_FILL, S_OUT} sstate_t;

   sstate_t           st_q, st_d;
   logic [DWIDTH-1:0] mem_q [DEPTH];
   logic [DWIDTH-1:0] mem_d [DEPTH];
   logic [AWIDTH-1:0] cnt_q, cnt_d, rd_q, rd_d, pos, cnt_inc;
   logic [DWIDTH-1:0] dout_q, dout_d;
   logic              sop_q, sop_d, eop_q, eop_d, val_q, val_d;

   always_comb begin
      st_d    = st_q;
      mem_d   = mem_q;
      cnt_d   = cnt_q;
      rd_d    = rd_q;
      dout_d  = '0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
      val_d   = 1'b0;
      cnt_inc = cnt_q + 1'b1;
      // insertion point: after every stored word <= data_i (keeps equal keys stable)
      pos = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (AWIDTH'(i) < cnt_q && mem_q[i] <= data_i) pos = pos + 1'b1;
      end
      case (st_q)
         S_FILL: begin
            if (wren_i) begin
               for (int unsigned i = 1; i < DEPTH; i++) begin
                  if (AWIDTH'(i) > pos) mem_d[i] = mem_q[i-1];
               end
               mem_d[pos] = data_i;
               cnt_d      = cnt_inc;
               if (cnt_inc == cntr_i) begin
                  st_d = S_OUT;
                  rd_d = '0;
               end
            end
         end
         S_OUT: begin
            val_d  = 1'b1;
            dout_d = mem_q[rd_q];
            sop_d  = (rd_q == '0);
            eop_d  = (rd_q == cnt_q - 1'b1);
            rd_d   = rd_q + 1'b1;
            if (eop_d) begin
               st_d  = S_FILL;
               cnt_d = '0;
            end
         end
         default: st_d = S_FILL;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         st_q   <= S_FILL;
         cnt_q  <= '0;
         rd_q   <= '0;
         dout_q <= '0;
         sop_q  <= 1'b0;
         eop_q  <= 1'b0;
         val_q  <= 1'b0;
      end else begin
         st_q   <= st_d;
         mem_q  <= mem_d;
         cnt_q  <= cnt_d;
         rd_q   <= rd_d;
         dout_q <= dout_d;
         sop_q  <= sop_d;
         eop_q  <= eop_d;
         val_q  <= val_d;
      end
   end

   assign data_o = dout_q;
   assign sop_o  = sop_q;
   assign eop_o  = eop_q;
   assign val_o  = val_q;
endmodule

module sorter_pkt_ctrl #(
   parameter int DWIDTH  = 8,
   parameter int AWIDTH  = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [DWIDTH-1:0] snk_data_i,
   input  logic              snk_sop_i,
   input  logic              snk_eop_i,
   input  logic              snk_val_i,
   output logic              snk_ready_o,
   output logic [DWIDTH-1:0] src_data_o,
   output logic              src_sop_o,
   output logic              src_eop_o,
   output logic              src_val_o,
   output logic              err_o,
   output logic [1:0]        err_code_o,
   output logic              busy_o
);
   localparam int DEPTH = 2**AWIDTH;
   localparam logic [AWIDTH-1:0] MAXLEN = AWIDTH'(DEPTH - 1);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {IDLE, RECV, DROP, LOAD, WAIT} state_t;

   state_t            state_q, state_d;
   logic [DWIDTH-1:0] buf_q [DEPTH];
   logic [DWIDTH-1:0] buf_d [DEPTH];
   logic [AWIDTH-1:0] len_q, len_d, idx_q, idx_d, cntr_q, cntr_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic              err_q, err_d;
   logic [1:0]        code_q, code_d;
   logic [DWIDTH-1:0] src_data_q, src_data_d;
   logic              src_sop_q, src_sop_d, src_eop_q, src_eop_d, src_val_q, src_val_d;
   logic [1:0]        sync_q, sync_d;
   logic              srst_pulse_q, srst_pulse_d;

   logic              beat;
   logic [DWIDTH-1:0] sorter_data;
   logic              sorter_sop, sorter_eop, sorter_val;

   // ready is also held low while the sorter is still coming out of reset
   assign snk_ready_o = (state_q == IDLE || state_q == RECV || state_q == DROP) && !sync_q[1];
   assign beat        = snk_val_i && snk_ready_o;

   sorter_core #(
      .DWIDTH (DWIDTH),
      .AWIDTH (AWIDTH)
   ) u_sorter (
      .clk_i  (clk_i),
      .srst_i (sync_q[1] | srst_pulse_q),
      .wren_i (state_q == LOAD),
      .data_i (buf_q[idx_q]),
      .cntr_i (cntr_q),
      .data_o (sorter_data),
      .sop_o  (sorter_sop),
      .eop_o  (sorter_eop),
      .val_o  (sorter_val)
   );

   always_comb begin
      state_d      = state_q;
      buf_d        = buf_q;
      len_d        = len_q;
      idx_d        = idx_q;
      cntr_d       = cntr_q;
      timer_d      = timer_q;
      err_d        = 1'b0;
      code_d       = '0;
      src_data_d   = '0;
      src_sop_d    = 1'b0;
      src_eop_d    = 1'b0;
      src_val_d    = 1'b0;
      srst_pulse_d = 1'b0;
      sync_d       = {sync_q[0], 1'b0};
      case (state_q)
         IDLE: begin
            if (beat && snk_sop_i) begin
               if (snk_eop_i) begin
                  err_d  = 1'b1;
                  code_d = 2'd1;
               end else begin
                  state_d  = RECV;
                  buf_d[0] = snk_data_i;
                  len_d    = AWIDTH'(1);
               end
            end
         end
         RECV: begin
            if (beat) begin
               if (snk_sop_i) begin
                  if (snk_eop_i) begin
                     err_d   = 1'b1;
                     code_d  = 2'd1;
                     state_d = IDLE;
                  end else begin
                     buf_d[0] = snk_data_i;
                     len_d    = AWIDTH'(1);
                  end
               end else if (len_q == MAXLEN) begin
                  if (snk_eop_i) begin
                     err_d   = 1'b1;
                     code_d  = 2'd2;
                     state_d = IDLE;
                  end else begin
                     state_d = DROP;
                  end
               end else begin
                  buf_d[len_q] = snk_data_i;
                  len_d        = len_q + 1'b1;
                  if (snk_eop_i) begin
                     state_d = LOAD;
                     idx_d   = '0;
                     cntr_d  = len_q + 1'b1;
                  end
               end
            end
         end
         DROP: begin
            if (beat && snk_eop_i) begin
               err_d   = 1'b1;
               code_d  = 2'd2;
               state_d = IDLE;
            end
         end
         LOAD: begin
            idx_d = idx_q + 1'b1;
            if (idx_q == len_q - 1'b1) begin
               state_d = WAIT;
               timer_d = '0;
            end
         end
         WAIT: begin
            timer_d    = timer_q + 1'b1;
            src_data_d = sorter_data;
            src_sop_d  = sorter_sop;
            src_eop_d  = sorter_eop;
            src_val_d  = sorter_val;
            if (sorter_eop) begin
               state_d = IDLE;
               cntr_d  = '0;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               err_d        = 1'b1;
               code_d       = 2'd3;
               srst_pulse_d = 1'b1;
               state_d      = IDLE;
               cntr_d       = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= IDLE;
         buf_q        <= '{default: '0};
         len_q        <= '0;
         idx_q        <= '0;
         cntr_q       <= '0;
         timer_q      <= '0;
         err_q        <= 1'b0;
         code_q       <= '0;
         src_data_q   <= '0;
         src_sop_q    <= 1'b0;
         src_eop_q    <= 1'b0;
         src_val_q    <= 1'b0;
         sync_q       <= 2'b11;
         srst_pulse_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         buf_q        <= buf_d;
         len_q        <= len_d;
         idx_q        <= idx_d;
         cntr_q       <= cntr_d;
         timer_q      <= timer_d;
         err_q        <= err_d;
         code_q       <= code_d;
         src_data_q   <= src_data_d;
         src_sop_q    <= src_sop_d;
         src_eop_q    <= src_eop_d;
         src_val_q    <= src_val_d;
         sync_q       <= sync_d;
         srst_pulse_q <= srst_pulse_d;
      end
   end

   assign src_data_o = src_data_q;
   assign src_sop_o  = src_sop_q;
   assign src_eop_o  = src_eop_q;
   assign src_val_o  = src_val_q;
   assign err_o      = err_q;
   assign err_code_o = code_q;
   assign busy_o     = (state_q != IDLE);
endmodule

// File: tb/tb_sorter_pkt_ctrl.sv
module tb_sorter_pkt_ctrl;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] snk_data = '0;
   logic       snk_sop = 1'b0, snk_eop = 1'b0, snk_val = 1'b0;
   logic       snk_ready;
   logic [7:0] src_data;
   logic       src_sop, src_eop, src_val;
   logic       err;
   logic [1:0] err_code;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   // capture results
   logic [7:0] cap_data [32];
   int         cap_n, cap_sop_pos, cap_eop_pos;
   bit         cap_gap, cap_busy_eop, cap_timeout;

   always #5 clk = ~clk;

   sorter_pkt_ctrl #(
      .DWIDTH (8),
      .AWIDTH (4),
      .TIMEOUT(32)
   ) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .snk_data_i (snk_data),
      .snk_sop_i  (snk_sop),
      .snk_eop_i  (snk_eop),
      .snk_val_i  (snk_val),
      .snk_ready_o(snk_ready),
      .src_data_o (src_data),
      .src_sop_o  (src_sop),
      .src_eop_o  (src_eop),
      .src_val_o  (src_val),
      .err_o      (err),
      .err_code_o (err_code),
      .busy_o     (busy)
   );

   // drive one input beat; waits (bounded) for ready first
   task automatic beat(input logic [7:0] d, input logic s, input logic e);
      int waited = 0;
      @(negedge clk);
      while (!snk_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!snk_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL ready_wait: ready=%0b required 1", snk_ready);
      end
      snk_data = d;
      snk_sop  = s;
      snk_eop  = e;
      snk_val  = 1'b1;
   endtask

   task automatic end_beats();
      @(negedge clk);
      snk_val  = 1'b0;
      snk_sop  = 1'b0;
      snk_eop  = 1'b0;
      snk_data = '0;
   endtask

   // record src stream until eop or budget expiry
   task automatic capture(input int budget);
      bit started = 0;
      cap_n = 0; cap_sop_pos = -1; cap_eop_pos = -1;
      cap_gap = 0; cap_busy_eop = 1; cap_timeout = 1;
      for (int c = 0; c < budget; c++) begin
         if (src_val) begin
            if (cap_n < 32) cap_data[cap_n] = src_data;
            if (src_sop && cap_sop_pos < 0) cap_sop_pos = cap_n;
            if (src_eop) begin
               cap_eop_pos  = cap_n;
               cap_busy_eop = busy;
            end
            cap_n++;
            started = 1;
            if (src_eop) begin
               cap_timeout = 0;
               break;
            end
         end else if (started) begin
            cap_gap = 1;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      n_checks++;
      if ({snk_ready, src_val, src_sop, src_eop, src_data, err, err_code, busy} !== 15'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h required 0",
                  {snk_ready, src_val, src_sop, src_eop, src_data, err, err_code, busy});
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if (snk_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready_after: got %b required 1", snk_ready);
      end
   endtask

   task automatic test_basic();
      logic [7:0] exp [3] = '{8'd1, 8'd2, 8'd3};
      beat(8'd3, 1, 0); beat(8'd1, 0, 0); beat(8'd2, 0, 1);
      end_beats();
      capture(60);
      n_checks++;
      if (cap_timeout || cap_n != 3) begin
         n_fail++;
         $display("FAIL basic_count: got %0d words (timeout=%0b) required 3", cap_n, cap_timeout);
      end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (cap_data[i] !== exp[i]) begin
            n_fail++;
            $display("FAIL basic_word%0d: got %0d required %0d", i, cap_data[i], exp[i]);
         end
      end
      n_checks++;
      if (cap_sop_pos != 0 || cap_eop_pos != 2 || cap_gap) begin
         n_fail++;
         $display("FAIL basic_framing: sop@%0d eop@%0d gap=%0b required sop@0 eop@2 gap=0",
                  cap_sop_pos, cap_eop_pos, cap_gap);
      end
   endtask

   task automatic test_maxlen();
      for (int i = 0; i < 15; i++) beat(8'(15 - i), i == 0, i == 14);
      end_beats();
      capture(80);
      n_checks++;
      if (cap_timeout || cap_n != 15) begin
         n_fail++;
         $display("FAIL maxlen_count: got %0d required 15", cap_n);
      end
      for (int i = 0; i < 15; i++) begin
         n_checks++;
         if (cap_data[i] !== 8'(i + 1)) begin
            n_fail++;
            $display("FAIL maxlen_word%0d: got %0d required %0d", i, cap_data[i], i + 1);
         end
      end
      n_checks++;
      if (cap_sop_pos != 0 || cap_eop_pos != 14 || cap_gap) begin
         n_fail++;
         $display("FAIL maxlen_framing: sop@%0d eop@%0d gap=%0b required 0/14/0",
                  cap_sop_pos, cap_eop_pos, cap_gap);
      end
      n_checks++;
      if (cap_busy_eop !== 1'b0) begin
         n_fail++;
         $display("FAIL maxlen_busy_at_eop: got %b required 0", cap_busy_eop);
      end
   endtask

   task automatic test_errors();
      // single-word packet
      beat(8'd42, 1, 1);
      end_beats();
      n_checks++;
      if (err !== 1'b1 || err_code !== 2'd1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL short_err: err=%b code=%0d busy=%b required 1/1/0", err, err_code, busy);
      end
      @(negedge clk);
      n_checks++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL short_err_pulse: got %b required 0", err);
      end
      capture(40);
      n_checks++;
      if (cap_n != 0) begin
         n_fail++;
         $display("FAIL short_no_output: got %0d words required 0", cap_n);
      end
      // 16 words: oversize reported on the eop beat
      for (int i = 0; i < 16; i++) beat(8'(i), i == 0, i == 15);
      end_beats();
      n_checks++;
      if (err !== 1'b1 || err_code !== 2'd2 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL over16_err: err=%b code=%0d busy=%b required 1/2/0", err, err_code, busy);
      end
      // 18 words: goes through the drop state, error only at eop
      for (int i = 0; i < 17; i++) beat(8'(i), i == 0, 0);
      @(negedge clk);
      n_checks++;
      if (err !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL drop_midway: err=%b busy=%b required 0/1", err, busy);
      end
      snk_val = 1'b0;
      beat(8'd99, 0, 1);
      end_beats();
      n_checks++;
      if (err !== 1'b1 || err_code !== 2'd2 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL drop_err: err=%b code=%0d busy=%b required 1/2/0", err, err_code, busy);
      end
      capture(40);
      n_checks++;
      if (cap_n != 0) begin
         n_fail++;
         $display("FAIL oversize_no_output: got %0d words required 0", cap_n);
      end
   endtask

   task automatic test_sop_restart();
      // stray beats while idle are ignored
      beat(8'd33, 0, 0); beat(8'd44, 0, 1);
      end_beats();
      n_checks++;
      if (busy !== 1'b0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL stray_ignored: busy=%b err=%b required 0/0", busy, err);
      end
      beat(8'd9, 1, 0); beat(8'd8, 0, 0); beat(8'd5, 1, 0); beat(8'd4, 0, 1);
      end_beats();
      capture(60);
      n_checks++;
      if (cap_timeout || cap_n != 2 || cap_data[0] !== 8'd4 || cap_data[1] !== 8'd5) begin
         n_fail++;
         $display("FAIL restart_output: n=%0d w0=%0d w1=%0d required n=2 4,5",
                  cap_n, cap_data[0], cap_data[1]);
      end
   endtask

   task automatic test_timeout();
      int k = 1;
      force dut.sorter_eop = 1'b0;
      beat(8'd3, 1, 0); beat(8'd1, 0, 0); beat(8'd2, 0, 1);
      end_beats();
      // k counts clock edges since the eop beat was taken
      while (!err && k < 100) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (k != 36) begin
         n_fail++;
         $display("FAIL timeout_latency: err after %0d cycles required 36", k);
      end
      n_checks++;
      if (err !== 1'b1 || err_code !== 2'd3 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_err: err=%b code=%0d busy=%b required 1/3/0", err, err_code, busy);
      end
      release dut.sorter_eop;
      repeat (3) @(negedge clk);
      beat(8'd6, 1, 0); beat(8'd5, 0, 1);
      end_beats();
      capture(60);
      n_checks++;
      if (cap_timeout || cap_n != 2 || cap_data[0] !== 8'd5 || cap_data[1] !== 8'd6) begin
         n_fail++;
         $display("FAIL timeout_recovery: n=%0d w0=%0d w1=%0d required n=2 5,6",
                  cap_n, cap_data[0], cap_data[1]);
      end
   endtask

   task automatic test_async_reset();
      beat(8'd3, 1, 0); beat(8'd1, 0, 0); beat(8'd2, 0, 1);
      end_beats();
      repeat (4) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL areset_pre_busy: got %b required 1", busy);
      end
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({src_val, src_sop, src_eop, src_data, err, err_code, busy, snk_ready} !== 15'd0) begin
         n_fail++;
         $display("FAIL areset_outputs: got %h required 0",
                  {src_val, src_sop, src_eop, src_data, err, err_code, busy, snk_ready});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      beat(8'd2, 1, 0); beat(8'd7, 0, 1);
      end_beats();
      capture(60);
      n_checks++;
      if (cap_timeout || cap_n != 2 || cap_data[0] !== 8'd2 || cap_data[1] !== 8'd7) begin
         n_fail++;
         $display("FAIL areset_next_pkt: n=%0d w0=%0d w1=%0d required n=2 2,7",
                  cap_n, cap_data[0], cap_data[1]);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_maxlen();
      test_errors();
      test_sop_restart();
      test_timeout();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
